// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-RAM access controller: op encodings, access
// size decode, FSM state encoding and RAM byte-lane select constants.
package mem_access_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned SEL_W  = 4;

  localparam logic [OP_W-1:0] OP_LB  = 3'b000;
  localparam logic [OP_W-1:0] OP_LH  = 3'b001;
  localparam logic [OP_W-1:0] OP_LW  = 3'b010;
  localparam logic [OP_W-1:0] OP_SW  = 3'b011;
  localparam logic [OP_W-1:0] OP_LBU = 3'b100;
  localparam logic [OP_W-1:0] OP_LHU = 3'b101;
  localparam logic [OP_W-1:0] OP_SB  = 3'b110;
  localparam logic [OP_W-1:0] OP_SH  = 3'b111;

  localparam logic [SEL_W-1:0] SEL_BYTE0   = 4'b0001;
  localparam logic [SEL_W-1:0] SEL_BYTE1   = 4'b0010;
  localparam logic [SEL_W-1:0] SEL_BYTE2   = 4'b0100;
  localparam logic [SEL_W-1:0] SEL_BYTE3   = 4'b1000;
  localparam logic [SEL_W-1:0] SEL_HALF_LO = 4'b0011;
  localparam logic [SEL_W-1:0] SEL_HALF_HI = 4'b1100;
  localparam logic [SEL_W-1:0] SEL_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
  endfunction

  function automatic size_e op_size(input logic [OP_W-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
      default:              return SIZE_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [OP_W-1:0] op, input logic [1:0] addr_lo);
    case (op_size(op))
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      default:   return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: lane selects and replicated store data on
// the way out, sign/zero extension of the already-shifted RAM data on the way in.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] ram_data_out,
  output logic [3:0]  sel_c,
  output logic [31:0] store_data_c,
  output logic [31:0] load_data_c,
  output logic        misalign_c
);

  always_comb begin
    sel_c = SEL_WORD;
    case (op_size(op))
      SIZE_BYTE: begin
        case (addr_lo)
          2'd0:    sel_c = SEL_BYTE0;
          2'd1:    sel_c = SEL_BYTE1;
          2'd2:    sel_c = SEL_BYTE2;
          default: sel_c = SEL_BYTE3;
        endcase
      end
      SIZE_HALF: sel_c = addr_lo[1] ? SEL_HALF_HI : SEL_HALF_LO;
      default:   sel_c = SEL_WORD;
    endcase
  end

  // Store data is replicated so the RAM can pick any lane without a shifter.
  always_comb begin
    store_data_c = wdata;
    case (op)
      OP_SB:   store_data_c = {4{wdata[7:0]}};
      OP_SH:   store_data_c = {2{wdata[15:0]}};
      default: store_data_c = wdata;
    endcase
  end

  always_comb begin
    load_data_c = ram_data_out;
    case (op)
      OP_LB:   load_data_c = {{24{ram_data_out[7]}}, ram_data_out[7:0]};
      OP_LBU:  load_data_c = {24'd0, ram_data_out[7:0]};
      OP_LH:   load_data_c = {{16{ram_data_out[15]}}, ram_data_out[15:0]};
      OP_LHU:  load_data_c = {16'd0, ram_data_out[15:0]};
      default: load_data_c = ram_data_out;
    endcase
  end

  assign misalign_c = is_misaligned(op, addr_lo);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator for the single-port byte-select data RAM: one access per
// request, registered RAM strobes, one-cycle read latency, done/busy handshake.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic              ram_rw,
  output logic [3:0]        ram_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_data_in,
  input  logic [31:0]       ram_data_out
);

  state_e      state;
  logic [2:0]  op_q;
  logic [1:0]  addr_lo_q;
  logic [2:0]  align_op;
  logic [1:0]  align_lo;
  logic [3:0]  sel_c;
  logic [31:0] store_data_c;
  logic [31:0] load_data_c;
  logic        misalign_c;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  // Live request fields while idle, latched ones once the access is in flight.
  assign align_op = (state == ST_IDLE) ? op : op_q;
  assign align_lo = (state == ST_IDLE) ? addr[1:0] : addr_lo_q;

  mem_lane_align u_lane_align (
    .op           (align_op),
    .addr_lo      (align_lo),
    .wdata        (wdata),
    .ram_data_out (ram_data_out),
    .sel_c        (sel_c),
    .store_data_c (store_data_c),
    .load_data_c  (load_data_c),
    .misalign_c   (misalign_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      addr_lo_q   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      misalign    <= 1'b0;
      rdata       <= '0;
      ram_rw      <= 1'b0;
      ram_sel     <= '0;
      ram_addr    <= '0;
      ram_data_in <= '0;
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (misalign_c) begin
              done     <= 1'b1;
              misalign <= 1'b1;
              rdata    <= '0;
            end else begin
              op_q        <= op;
              addr_lo_q   <= addr[1:0];
              ram_addr    <= addr[ADDR_W+1:2];
              ram_sel     <= sel_c;
              ram_rw      <= is_store(op);
              ram_data_in <= store_data_c;
              busy        <= 1'b1;
              state       <= ST_ACCESS;
            end
          end
        end
        // RAM samples at the end of this cycle; strobes drop right after.
        ST_ACCESS: begin
          ram_rw  <= 1'b0;
          ram_sel <= '0;
          if (is_store(op_q)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          rdata <= load_data_c;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Initiator for the single-port byte-select data RAM: the MEM stage hands it one load/store per request, and it drives the RAM's `ram_rw`/`ram_sel`/`ram_addr`/`ram_data_in` port. It accounts for the RAM's one-cycle registered read latency and checks alignment. It extracts and sign- or zero-extends sub-word load data and returns a `done` pulse. It holds `busy` so the pipeline stalls while an access is in flight.

## Interface
Parameters:
- ADDR_W, 10, RAM word-address width; byte address bits [ADDR_W+1:2] select the word.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  1  request strobe; accepted only when busy=0
- op  in  3  000 LB, 001 LH, 010 LW, 011 SW, 100 LBU, 101 LHU, 110 SB, 111 SH
- addr  in  32  byte address; bits above ADDR_W+1 ignored
- wdata  in  32  store data, right-justified
- busy  out  1  access in flight (state≠IDLE)
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result, valid while done=1, held until next done
- misalign  out  1  with done: request rejected, no RAM access
- ram_rw  out  1  1=write
- ram_sel  out  4  byte-lane enables
- ram_addr  out  ADDR_W  word address
- ram_data_in  out  32  lane-replicated store data
- ram_data_out  in  32  RAM read data (lane already shifted to bits[7:0]/[15:0], zero-filled)

## Operation
- States: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE with req=1:
  - Aligned: latch op and addr[1:0]. Drive ram_addr=addr[ADDR_W+1:2], ram_sel, ram_rw=is_store, ram_data_in. Go to ACCESS.
  - Misaligned: go to IDLE next with done=1, misalign=1, rdata=0, no RAM strobe.
- Misaligned means halfword ops with addr[0]=1, or word ops with addr[1:0]≠0.
- ram_sel by access size:
  - Byte: 4'b0001<<addr[1:0].
  - Half: addr[1] ? 1100 : 0011.
  - Word: 1111.
- ram_data_in by op:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- ACCESS (the RAM samples at the end of this cycle):
  - Store: go to IDLE with done=1. Clear ram_rw and ram_sel.
  - Load: go to RESP. Clear ram_sel; ram_addr holds.
- RESP: register rdata from ram_data_out and pulse done=1. Go to IDLE.
  - LB: sign-extend bit 7.
  - LBU: zero-extend.
  - LH: sign-extend bit 15.
  - LHU: zero-extend.
  - LW: pass through.
- req while busy=1 is ignored (pipeline must hold it, stalled on busy).
- req in the same cycle as done is accepted (done is asserted in IDLE).

## Timing
- Reset values: state IDLE; busy, done, misalign, ram_rw = 0; ram_sel, ram_addr, ram_data_in, rdata = 0.
- A req sampled at edge E0 gives the following sequence:
  - ram_* valid E0→E1 and the RAM acts at E1.
  - Store: done=1 in cycle E1→E2, latency 2.
  - Load: RESP in E1→E2, done=1 and rdata valid in E2→E3, latency 3.
  - Misaligned: done=1 in E0→E1, latency 1.
- busy=1 exactly while in ACCESS/RESP.
- ram_rw is high for exactly one cycle per store and is never high outside ACCESS.
- rst sampled high at any edge: the next cycle is IDLE with all outputs at reset values and any in-flight access dropped. A store whose ACCESS edge coincides with rst is not committed by contract; the RAM's own rst clears memory anyway.

## Structure
- Shared package holds:
  - op encodings and is_store/size decode constants;
  - state encoding;
  - the SEL_BYTE0..3, SEL_HALF_LO/HI, SEL_WORD constants, which the RAM case decode also uses.
- One natural sub-module: `mem_lane_align`, combinational. It produces sel and replicated store data from op/addr[1:0], and extended load data from op/ram_data_out.
- The FSM and registers stay in the top.

## Test plan
- SW addr=0x10, wdata=0xDEADBEEF → ram_rw=1 for one cycle, ram_addr=4, ram_sel=1111, done at +2. A following LW 0x10 returns rdata=0xDEADBEEF at +3.
- SB addr=0x13, wdata=0x80 → ram_sel=1000, ram_data_in=0x80808080. LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080.
- SH addr=0x22, wdata=0x8001 → ram_sel=1100. LH 0x22 → 0xFFFF8001; LHU → 0x00008001; LW 0x20 upper half=0x8001.
- LW addr=0x11 and LH addr=0x13 → done+misalign at +1, rdata=0, ram_sel stays 0, no RAM write.
- req held high continuously with alternating ops → each accepted only in IDLE, busy covers gaps, no dropped or duplicated done pulses.
- rst asserted during ACCESS of a load → next cycle IDLE, done=0, busy=0, all ram_* outputs 0. A new req after rst falls completes normally.
